// File: rtl/decimal_entry_to_binary.sv
// Push-button decimal entry (4 BCD digits) with live 7-seg display and iterative BCD-to-binary conversion.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module decimal_entry_to_binary #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_BITS    = 18,
  parameter int OUT_W           = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_enter,
  output logic [OUT_W-1:0] led,
  output logic             valid,
  output logic             overflow,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int RW    = REFRESH_BITS + 2;
  localparam int ACC_W = 14;
  localparam logic [31:0] MAXV = 32'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 enter
  logic [4:0]       btn_raw;
  logic [4:0]       sync1_q, sync2_q, db_q, db_prev_q, pulse_q;
  logic [CNT_W-1:0] cnt_q [5];

  assign btn_raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      pulse_q   <= db_q & ~db_prev_q;
      // A level is accepted only after an unbroken run of disagreement
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_t             state_q, state_d;
  logic [3:0]         digit_q [4];
  logic [3:0]         digit_d [4];
  logic [1:0]         cursor_q, cursor_d;
  logic [1:0]         k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_n;
  logic [OUT_W-1:0]   led_q, led_d;
  logic               ovf_q, ovf_d, ovf_n;

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cursor_d = cursor_q;
    k_d      = k_q;
    acc_d    = acc_q;
    led_d    = led_q;
    ovf_d    = ovf_q;
    acc_n    = acc_q * ACC_W'(10) + ACC_W'(digit_q[k_q]);
    ovf_n    = 32'(acc_n) > MAXV;
    case (state_q)
      S_IDLE: begin
        if (pulse_q[4]) begin
          state_d = S_CONV;
          acc_d   = '0;
          k_d     = 2'd3;
        end else if (pulse_q[0]) begin
          digit_d[cursor_q] = (digit_q[cursor_q] == 4'd9) ? 4'd0 : digit_q[cursor_q] + 4'd1;
        end else if (pulse_q[1]) begin
          digit_d[cursor_q] = (digit_q[cursor_q] == 4'd0) ? 4'd9 : digit_q[cursor_q] - 4'd1;
        end else if (pulse_q[2]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (pulse_q[3]) begin
          cursor_d = cursor_q - 2'd1;
        end
      end
      S_CONV: begin
        acc_d = acc_n;
        k_d   = k_q - 2'd1;
        if (k_q == 2'd0) begin
          state_d = S_DONE;
          ovf_d   = ovf_n;
          led_d   = ovf_n ? '1 : OUT_W'(acc_n);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
      cursor_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      led_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cursor_q <= cursor_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
    end
  end

  assign led      = led_q;
  assign overflow = ovf_q;
  assign valid    = (state_q == S_DONE);

  logic [RW-1:0] refresh_q;
  logic [1:0]    sel;
  logic          blink_on;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  assign sel = refresh_q[RW-1 -: 2];

`ifdef CURSOR_BLINK_EN
  logic [24:0] blink_div_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_div_q <= '0;
    else       blink_div_q <= blink_div_q + 1'b1;
  end
  assign blink_on = refresh_q[RW-1] ^ blink_div_q[24];
`else
  assign blink_on = 1'b0;
`endif

  always_comb begin
    an_d      = 4'b1111;
    an_d[sel] = 1'b0;
    seg_d     = seg_code(digit_q[sel]);
    if (blink_on && (sel == cursor_q)) seg_d = 7'b1111111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Directed bench for decimal_entry_to_binary with a decimal-level reference model and per-cycle output compare.
module tb_decimal_entry_to_binary;

  localparam int DEB = 4;
  localparam int RB  = 2;
  localparam int OW  = 13;
  localparam int OMAX = (1 << OW) - 1;
  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LF = 5'b00100, RT = 5'b01000, EN = 5'b10000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    btn = '0;
  logic [OW-1:0] led;
  logic          valid, overflow;
  logic [3:0]    an;
  logic [6:0]    seg;

  decimal_entry_to_binary #(.DEBOUNCE_CYCLES(DEB), .REFRESH_BITS(RB), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_enter(btn[4]),
    .led(led), .valid(valid), .overflow(overflow), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model state, in decimal terms
  int mdig [4];
  int mcur, mled, mcnt, snap_s;
  int snap_dig [4];
  bit movf, mvalid, live;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdig[i] = 0;
    mcur = 0; mled = 0; movf = 0; mvalid = 0;
  endtask

  task automatic model_edit(input logic [4:0] m);
    if (m[4]) begin
    end else if (m[0]) mdig[mcur] = (mdig[mcur] == 9) ? 0 : mdig[mcur] + 1;
    else if (m[1]) mdig[mcur] = (mdig[mcur] == 0) ? 9 : mdig[mcur] - 1;
    else if (m[2]) mcur = (mcur + 1) % 4;
    else if (m[3]) mcur = (mcur + 3) % 4;
  endtask

  // Press lands in cycle t0; pulse at t0+DEB+3, edit visible at t0+DEB+4, result at pulse+5
  task automatic press(input logic [4:0] m);
    int v;
    @(posedge clk); #1;
    btn = m;
    fork
      begin
        repeat (8) @(posedge clk); #1;
        btn = '0;
      end
      begin
        repeat (DEB + 4) @(posedge clk);
        model_edit(m);
        if (m[4]) begin
          v = mdig[3] * 1000 + mdig[2] * 100 + mdig[1] * 10 + mdig[0];
          repeat (4) @(posedge clk);
          mled = (v > OMAX) ? OMAX : v;
          movf = (v > OMAX);
          mvalid = 1;
          @(posedge clk);
          mvalid = 0;
        end
      end
    join
    repeat (12) @(posedge clk);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mcnt = 0;
      live = 0;
    end else begin
      mcnt = (mcnt + 1) % (1 << (RB + 2));
      live = 1;
    end
  end

  always @(negedge clk) begin
    if (reset || !live) begin
      check("an", 32'(an), 32'hF);
      check("seg", 32'(seg), 32'h7F);
    end else begin
      check("an", 32'(an), 32'(4'hF & ~(4'b1 << snap_s)));
      check("seg", 32'(seg), 32'(seg_tab[snap_dig[snap_s]]));
    end
    check("led", 32'(led), mled);
    check("valid", 32'(valid), 32'(mvalid));
    check("overflow", 32'(overflow), 32'(movf));
    snap_s = mcnt >> RB;
    for (int i = 0; i < 4; i++) snap_dig[i] = mdig[i];
  end

  initial begin
    model_reset();
    mcnt = 0; live = 0; snap_s = 0;
    for (int i = 0; i < 4; i++) snap_dig[i] = 0;
    repeat (3) @(posedge clk); #1;
    reset = 0;
    @(posedge clk); @(negedge clk);
    check("first_an", 32'(an), 32'b1110);
    check("first_seg", 32'(seg), 32'b0000001);
    check("reset_led", 32'(led), 0);
    check("reset_ovf", 32'(overflow), 0);

    // Bouncing up button never settles long enough
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1; repeat (2) @(posedge clk); #1;
      btn[0] = 1'b0; repeat (2) @(posedge clk); #1;
    end
    repeat (12) @(posedge clk);
    press(UP);
    check("bounce_d0", mdig[0], 1);

    // Enter 1234, using the left-cursor wrap
    repeat (3) press(LF);
    press(UP);
    press(LF);
    check("left_wrap", mcur, 0);
    repeat (3) press(UP);
    press(LF); repeat (3) press(UP);
    press(LF); repeat (2) press(UP);
    press(EN);
    check("model_1234", mled, 1234);
    check("led_1234", 32'(led), 1234);
    check("ovf_1234", 32'(overflow), 0);

    // Digit and cursor wrap-around
    repeat (2) press(RT);
    repeat (4) press(DN);
    press(DN);
    check("down_wrap", mdig[0], 9);
    press(RT);
    check("right_wrap", mcur, 3);
    repeat (2) press(DN);
    press(UP);
    check("up_wrap", mdig[3], 0);
    press(EN);
    check("led_239", 32'(led), 239);

    // 9999 saturates a 13-bit result
    press(DN);
    press(RT); repeat (3) press(DN);
    press(RT); repeat (4) press(DN);
    press(EN);
    check("led_sat", 32'(led), 32'h1FFF);
    check("ovf_set", 32'(overflow), 1);

    // 0100 clears the overflow flag
    press(UP);
    press(LF); repeat (2) press(UP);
    press(LF); press(UP);
    repeat (3) press(RT);
    press(UP);
    press(EN);
    check("led_100", 32'(led), 100);
    check("ovf_clr", 32'(overflow), 0);

    // Simultaneous up and enter: enter wins
    press(UP | EN);
    check("prio_d0", mdig[0], 0);
    check("prio_led", 32'(led), 100);

    // Reset two cycles into a conversion
    @(posedge clk); #1;
    btn = EN;
    repeat (8) @(posedge clk); #1;
    btn = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_led", 32'(led), 0);
    check("abort_valid", 32'(valid), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
